// File: rtl/puf_resp_collector.sv
// PUF response collector: seeds the challenge LFSR, steps it once per word, waits
// for the PUF to settle, majority-votes NVOTE samples per bit and packs NUM_WORDS words MSB-first.
module puf_resp_collector #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned CHAL_W     = 16,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NVOTE      = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CHAL_W-1:0]             challenge_seed,
  output logic [CHAL_W-1:0]             lfsr_seed,
  output logic                          lfsr_start,
  output logic                          lfsr_next,
  input  logic                          lfsr_done,
  input  logic [WORD_W-1:0]             puf_word,
  output logic [WORD_W*NUM_WORDS-1:0]   resp,
  output logic                          resp_valid,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [$clog2(NUM_WORDS):0]    word_idx
);

  localparam int unsigned RESP_W = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS) + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);
  localparam logic [RESP_W-1:0] SLOT_MASK = RESP_W'({WORD_W{1'b1}});

  typedef enum logic [2:0] {
    IDLE, SEED, STEP, SETTLE, SAMPLE, STORE, DONE, ERR
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [3:0]         phase_cnt;
  logic [2:0]         votes     [WORD_W];
  logic [2:0]         votes_inc [WORD_W];
  logic [WORD_W-1:0]  maj;
  logic [31:0]        store_sh;

  for (genvar g = 0; g < WORD_W; g++) begin : g_vote
    assign votes_inc[g] = votes[g] + 3'(puf_word[g]);
    assign maj[g]       = votes[g] > 3'(NVOTE / 2);
  end

  // Word k lands in the k-th slot from the top, so the first word ends up in the MSBs.
  always_comb begin
    store_sh = WORD_W * (NUM_WORDS - 1 - 32'(word_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    lfsr_start  = 1'b0;
    lfsr_next   = 1'b0;
    busy        = 1'b0;
    resp_valid  = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        resp_valid  = (state == DONE);
        timeout_err = (state == ERR);
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEED;
        end
      end
      SEED: begin
        busy       = 1'b1;
        lfsr_start = 1'b1;
        // A handshake on the last counted cycle still counts as success.
        if (lfsr_done)                              state_nxt = STEP;
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1))    state_nxt = ERR;
      end
      STEP: begin
        busy       = 1'b1;
        lfsr_start = 1'b1;
        lfsr_next  = 1'b1;
        state_nxt  = SETTLE;
      end
      SETTLE: begin
        busy       = 1'b1;
        lfsr_start = 1'b1;
        if (phase_cnt == 4'(SETTLE_CYC - 1)) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy       = 1'b1;
        lfsr_start = 1'b1;
        if (phase_cnt == 4'(NVOTE - 1)) state_nxt = STORE;
      end
      STORE: begin
        busy       = 1'b1;
        lfsr_start = 1'b1;
        state_nxt  = (word_idx == IDX_W'(NUM_WORDS - 1)) ? DONE : STEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_seed <= '0;
      resp      <= '0;
      word_idx  <= '0;
      tmo_cnt   <= '0;
      phase_cnt <= '0;
      votes     <= '{default: '0};
    end else begin
      if (accept) begin
        lfsr_seed <= challenge_seed;
        resp      <= '0;
        word_idx  <= '0;
        tmo_cnt   <= '0;
        phase_cnt <= '0;
        votes     <= '{default: '0};
      end
      case (state)
        SEED:   tmo_cnt <= tmo_cnt + 1'b1;
        SETTLE: phase_cnt <= (state_nxt == SAMPLE) ? '0 : phase_cnt + 1'b1;
        SAMPLE: begin
          phase_cnt <= (state_nxt == STORE) ? '0 : phase_cnt + 1'b1;
          votes     <= votes_inc;
        end
        STORE: begin
          resp     <= (resp & ~(SLOT_MASK << store_sh)) | (RESP_W'(maj) << store_sh);
          word_idx <= word_idx + 1'b1;
          votes    <= '{default: '0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Scoreboard bench for puf_resp_collector: a behavioural LFSR/PUF responder feeds
// vote samples; expected responses are queued at start and checked by a monitor.
module tb_puf_resp_collector;

  localparam int unsigned W      = 16;
  localparam int unsigned NW     = 8;
  localparam int unsigned CW     = 16;
  localparam int unsigned SC     = 2;
  localparam int unsigned NV     = 3;
  localparam int unsigned TO     = 16;
  localparam int unsigned RESP_W = W * NW;
  localparam int unsigned CPW    = 2 + SC + NV;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [CW-1:0]        challenge_seed;
  logic [CW-1:0]        lfsr_seed;
  logic                 lfsr_start;
  logic                 lfsr_next;
  logic                 lfsr_done;
  logic [W-1:0]         puf_word;
  logic [RESP_W-1:0]    resp;
  logic                 resp_valid;
  logic                 busy;
  logic                 timeout_err;
  logic [$clog2(NW):0]  word_idx;

  puf_resp_collector #(
    .WORD_W(W), .NUM_WORDS(NW), .CHAL_W(CW),
    .SETTLE_CYC(SC), .NVOTE(NV), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge_seed(challenge_seed),
    .lfsr_seed(lfsr_seed), .lfsr_start(lfsr_start), .lfsr_next(lfsr_next),
    .lfsr_done(lfsr_done), .puf_word(puf_word), .resp(resp),
    .resp_valid(resp_valid), .busy(busy), .timeout_err(timeout_err),
    .word_idx(word_idx)
  );

  typedef struct {
    bit                is_tmo;
    logic [RESP_W-1:0] resp;
    logic [CW-1:0]     seed;
    int                d;
  } exp_t;

  exp_t       exp_q[$];
  logic [W-1:0] samp [NW][NV];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_delay = -1;
  int seed_cyc0 = 0;
  int step_cyc0 = 0;
  int nwords = 0;
  int since = 1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_resp"},        resp,        '0);
    check({tag, "_lfsr_seed"},   lfsr_seed,   '0);
    check({tag, "_lfsr_start"},  lfsr_start,  '0);
    check({tag, "_lfsr_next"},   lfsr_next,   '0);
    check({tag, "_resp_valid"},  resp_valid,  '0);
    check({tag, "_busy"},        busy,        '0);
    check({tag, "_timeout_err"}, timeout_err, '0);
    check({tag, "_word_idx"},    word_idx,    '0);
  endtask

  // Fill per-word vote samples and return the bitwise-majority response, first word on top.
  task automatic gen(input int mode, output logic [RESP_W-1:0] x);
    int bad;
    int ones;
    logic [W-1:0] maj;
    bad = int'($urandom_range(0, NV - 1));
    x = '0;
    for (int k = 0; k < NW; k++) begin
      for (int v = 0; v < NV; v++) begin
        case (mode)
          0:       samp[k][v] = 16'h1234;
          1:       samp[k][v] = W'(k + 1);
          2:       samp[k][v] = W'($urandom);
          default: samp[k][v] = (k == 2 && v == bad) ? 16'hA5A4 : 16'hA5A5;
        endcase
      end
      for (int b = 0; b < W; b++) begin
        ones = 0;
        for (int v = 0; v < NV; v++) ones += int'(samp[k][v][b]);
        maj[b] = (2 * ones > NV);
      end
      x = (x << W) | RESP_W'(maj);
    end
  endtask

  // Responder: LFSR handshake (done on SEED cycle index done_delay) and PUF sample window.
  initial begin : responder
    int  cur;
    int  seed_idx;
    bit  step_seen;
    bit  prev_start;
    bit  prev_next;
    cur = NW; seed_idx = 0; step_seen = 1'b1; prev_start = 1'b0; prev_next = 1'b0;
    lfsr_done = 1'b0;
    puf_word  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        nwords = 0; since = 1000; cur = NW;
        step_seen = 1'b1; prev_start = 1'b0; prev_next = 1'b0;
        lfsr_done = 1'b0;
      end else begin
        if (lfsr_start && !prev_start) begin
          seed_cyc0 = cyc; seed_idx = 0; step_seen = 1'b0;
          nwords = 0; cur = NW; since = 1000;
        end else if (lfsr_start && !step_seen) begin
          seed_idx++;
        end
        if (lfsr_next) begin
          check("next_width", prev_next, '0);
          if (!step_seen) step_cyc0 = cyc;
          step_seen = 1'b1;
          cur = nwords;
          nwords++;
          since = 0;
        end else if (since < 1000) begin
          since++;
        end
        lfsr_done = (lfsr_start && !step_seen) ? (seed_idx == done_delay) : 1'($urandom);
        if (cur < NW && since >= SC + 1 && since <= SC + NV)
          puf_word = samp[cur][since - SC - 1];
        else
          puf_word = W'($urandom);
        prev_next  = lfsr_next;
        prev_start = lfsr_start;
      end
    end
  end

  initial begin : monitor
    bit   pv;
    bit   pt;
    exp_t e;
    pv = 1'b0;
    pt = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (busy) check("valid_while_busy", resp_valid, '0);
        if ((resp_valid && !pv) || (timeout_err && !pt)) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_end: resp_valid=%0b timeout_err=%0b with no run pending", resp_valid, timeout_err);
          end else begin
            e = exp_q.pop_front();
            check("end_timeout_err", timeout_err, e.is_tmo);
            check("end_resp_valid",  resp_valid,  !e.is_tmo);
            check("end_busy",        busy,        '0);
            check("end_lfsr_start",  lfsr_start,  '0);
            check("end_lfsr_seed",   lfsr_seed,   e.seed);
            if (e.is_tmo) begin
              check("err_resp",       resp,     '0);
              check("err_word_idx",   word_idx, '0);
              check("timeout_cycles", cyc - seed_cyc0, TO);
            end else begin
              check("resp",           resp,     e.resp);
              check("done_word_idx",  word_idx, NW);
              check("seed_cycles",    step_cyc0 - seed_cyc0, e.d + 1);
              check("word_cycles",    cyc - step_cyc0, NW * CPW);
              check("next_pulses",    nwords, NW);
            end
          end
        end
        pv = resp_valid;
        pt = timeout_err;
      end else begin
        pv = 1'b0;
        pt = 1'b0;
      end
    end
  end

  task automatic do_run(input int mode, input logic [CW-1:0] seed, input int d,
                        input bit poke, input bit abort);
    exp_t e;
    logic [RESP_W-1:0] x;
    int n;
    gen(mode, x);
    done_delay = d;
    e.is_tmo = (d < 0 || d >= int'(TO));
    e.resp   = x;
    e.seed   = seed;
    e.d      = d;
    if (!abort) exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1;
    challenge_seed = seed;
    @(posedge clk); #1;
    start = 1'b0;
    challenge_seed = ~seed;
    check("seed_latch",   lfsr_seed,   seed);
    check("valid_clr",    resp_valid,  '0);
    check("terr_clr",     timeout_err, '0);
    check("resp_clr",     resp,        '0);
    check("word_idx_clr", word_idx,    '0);
    check("seed_busy",    busy,        1);
    check("seed_lfsr_start", lfsr_start, 1);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("poke_busy", busy, 1);
      check("poke_seed_kept", lfsr_seed, seed);
    end
    if (abort) begin
      n = 0;
      do begin
        @(posedge clk); #2;
        n++;
      end while (!(nwords == 5 && since == SC + 1) && n < 2000);
      if (n >= 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL abort_wait: word 4 SAMPLE not reached within %0d cycles", n);
      end
      check("mid_word_idx", word_idx, 4);
      #1 rst_n = 1'b0;
      #1 check_zero("reset_mid");
      @(posedge clk); #1;
      check_zero("reset_hold");
      #2 rst_n = 1'b1;
      return;
    end
    n = 0;
    while (!(resp_valid || timeout_err) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL run_end: no resp_valid or timeout_err within %0d cycles", n);
    end
  endtask

  initial begin : main
    rst_n = 1'b1;
    start = 1'b0;
    challenge_seed = '0;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    do_run(0, 16'h1A2B, 3, 1'b0, 1'b0);
    do_run(1, 16'h0001, 0, 1'b0, 1'b0);
    do_run(3, 16'h3C3C, 3, 1'b0, 1'b0);
    do_run(0, 16'h5555, -1, 1'b0, 1'b0);
    do_run(2, 16'h7777, int'(TO) - 1, 1'b0, 1'b0);
    do_run(2, 16'h0F0F, int'(TO), 1'b0, 1'b0);
    do_run(2, 16'h1357, 5, 1'b1, 1'b0);
    do_run(2, 16'h2468, 3, 1'b0, 1'b1);
    do_run(2, 16'h9ABC, 1, 1'b0, 1'b0);
    do_run(2, 16'hBEEF, 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      do_run(2, CW'($urandom), int'($urandom_range(0, TO - 1)), 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/puf_resp_collector.md
Name: puf_resp_collector

Overview:
- Parametrised successor of the fixed 128-bit PUF response gatherer.
- Drives an external LFSR challenge generator and a PUF core, then assembles NUM_WORDS PUF words of WORD_W bits into one response vector.
- Adds per-run re-triggering, a configurable PUF settle delay, bitwise majority voting over repeated samples, and an LFSR-handshake timeout.
- Sits between the challenge LFSR/PUF pair and the key-generation/TRNG consumer.

Parameters:
- WORD_W, 16, PUF output word width.
- NUM_WORDS, 8, words per response; response width = WORD_W*NUM_WORDS.
- CHAL_W, 16, challenge seed width.
- SETTLE_CYC, 2, idle cycles after each lfsr_next before sampling; legal range 1..15.
- NVOTE, 1, samples per word for majority; odd, 1..7.
- TIMEOUT, 64, maximum cycles to wait for lfsr_done in SEED; legal range 2..2^16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE, DONE or ERR.
- challenge_seed  in  CHAL_W  seed latched on an accepted start.
- lfsr_seed  out  CHAL_W  registered copy of challenge_seed, driven to the LFSR.
- lfsr_start  out  1  LFSR load/enable; high from SEED until DONE/ERR.
- lfsr_next  out  1  one-cycle advance pulse to the LFSR.
- lfsr_done  in  1  LFSR seeded/ready indication.
- puf_word  in  WORD_W  PUF response for the current challenge.
- resp  out  WORD_W*NUM_WORDS  assembled response.
- resp_valid  out  1  resp complete and stable.
- busy  out  1  run in progress (SEED..STORE).
- timeout_err  out  1  last run aborted on timeout.
- word_idx  out  clog2(NUM_WORDS)+1  words stored so far.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every output 0 (resp, lfsr_seed, word_idx included). Counters and vote accumulators are cleared. Reset takes effect immediately, including mid-run.
- States: IDLE, SEED, STEP, SETTLE, SAMPLE, STORE, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - Latch challenge_seed into lfsr_seed.
  - Clear resp_valid, timeout_err, word_idx and resp.
  - Go to SEED the next cycle.
- start is ignored while busy.
- SEED:
  - lfsr_start=1, busy=1; the timeout counter increments each cycle.
  - lfsr_done=1 -> STEP.
  - Counter reaches TIMEOUT-1 without lfsr_done -> ERR.
  - lfsr_done arriving on the final counted cycle wins over the timeout.
- STEP: lfsr_next=1 for exactly one cycle -> SETTLE.
- SETTLE: lfsr_next=0; wait SETTLE_CYC cycles -> SAMPLE.
- SAMPLE:
  - NVOTE consecutive cycles; each bit of puf_word adds to a per-bit 3-bit count.
  - -> STORE.
- STORE:
  - Write word = bitwise (count > NVOTE/2) into slice resp[WORD_W*(NUM_WORDS-word_idx)-1 -: WORD_W]. The first word lands in the MSBs.
  - word_idx++ and clear the counts.
  - If word_idx was NUM_WORDS-1 -> DONE, else -> STEP.
- Cycles per word = 1+SETTLE_CYC+NVOTE+1 (defaults: 5).
- DONE: resp_valid=1, busy=0, lfsr_start=0, lfsr_next=0. resp is held until the next accepted start.
- ERR: timeout_err=1, busy=0, lfsr_start=0, resp_valid=0, resp=0.
- lfsr_done is ignored outside SEED.
- The PUF word is not re-checked during SETTLE.
- No partial response is ever flagged valid.

Test Plan:
- Constant word, defaults:
  - Stimulus: puf_word=16'h1234; lfsr_done 3 cycles after lfsr_start rises.
  - Response: resp={8{16'h1234}}; resp_valid rises exactly 40 cycles after first STEP; lfsr_next pulsed 8 times, each 1 cycle wide.
- Word ordering:
  - Stimulus: bench increments puf_word on each lfsr_next, starting at 0.
  - Response: resp=128'h0001_0002_0003_0004_0005_0006_0007_0008; word_idx=8.
- Majority voting, NVOTE=3:
  - Stimulus: puf_word=16'hA5A5 except 16'hA5A4 on one of the three SAMPLE cycles of word 2.
  - Response: all words 16'hA5A5.
- Timeout, TIMEOUT=16:
  - Stimulus: lfsr_done held 0.
  - Response: ERR after 16 SEED cycles; timeout_err=1, busy=0, lfsr_start=0, resp_valid=0.
- Reset mid-run and start-while-busy:
  - Stimulus: rst_n low during SAMPLE of word 4.
  - Response: all outputs 0 before the next clock edge.
  - Stimulus: start pulsed mid-run.
  - Response: ignored; lfsr_seed unchanged.
- Re-trigger from DONE:
  - Stimulus: start with seed 16'hBEEF.
  - Response: resp_valid=0 and lfsr_seed=16'hBEEF next cycle; new full response produced.
